// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter for a shared split-transaction bus: per-transaction grant,
// master-to-slave muxing, response routing back to the owner, and a hung-transaction watchdog.
module simple_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_MASTERS-1:0]   m_req_i,
  output logic [NUM_MASTERS-1:0]   m_grant_o,
  input  logic [32*NUM_MASTERS-1:0] m_addrData_i,
  input  logic [4*NUM_MASTERS-1:0] m_byteEnables_i,
  input  logic [8*NUM_MASTERS-1:0] m_burstSize_i,
  input  logic [NUM_MASTERS-1:0]   m_readNWrite_i,
  input  logic [NUM_MASTERS-1:0]   m_beginTransaction_i,
  input  logic [NUM_MASTERS-1:0]   m_dataValid_i,
  output logic [31:0]              m_addrData_o,
  output logic [NUM_MASTERS-1:0]   m_dataValid_o,
  output logic [NUM_MASTERS-1:0]   m_endTransaction_o,
  output logic [NUM_MASTERS-1:0]   m_error_o,
  output logic [31:0]              bus_addrData_o,
  output logic [3:0]               bus_byteEnables_o,
  output logic [7:0]               bus_burstSize_o,
  output logic                     bus_readNWrite_o,
  output logic                     bus_beginTransaction_o,
  output logic                     bus_dataValid_o,
  input  logic [31:0]              bus_addrData_i,
  input  logic                     bus_endTransaction_i,
  input  logic                     bus_dataValid_i,
  input  logic                     bus_busy_i,
  input  logic                     bus_error_i,
  output logic                     timeout_o
);

  localparam int unsigned N     = NUM_MASTERS;
  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CW    = IDX_W + 1;
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [N-1:0]     abort_q, abort_d;

  logic [31:0]      addr_a  [N];
  logic [3:0]       be_a    [N];
  logic [7:0]       burst_a [N];

  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             fwd_begin;
  logic             wd_hit;
  logic             slave_done;
  logic             rel;
  logic             wd_abort;
  logic             active;
  logic             in_busy;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign addr_a[gi]  = m_addrData_i[32*gi +: 32];
    assign be_a[gi]    = m_byteEnables_i[4*gi +: 4];
    assign burst_a[gi] = m_burstSize_i[8*gi +: 8];
  end

  // First requester at or after the pointer, wrapping modulo N.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic             found;
    logic [CW-1:0]    cand;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
    return sel;
  endfunction

  assign pick_idx   = rr_pick(m_req_i, ptr_q);
  assign next_ptr   = (gidx_q == IDX_W'(N - 1)) ? '0 : gidx_q + IDX_W'(1);
  assign fwd_begin  = (state_q == ST_GRANT) && m_beginTransaction_i[gidx_q] && !bus_busy_i;
  assign wd_hit     = WD_EN && (cnt_q == WD_LAST);
  assign slave_done = (bus_endTransaction_i && bus_dataValid_i) || bus_error_i;
  assign active     = (state_q != ST_IDLE);
  assign in_busy    = (state_q == ST_BUSY);

  // Next-state, grant, pointer and watchdog.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    abort_d   = '0;
    rel       = 1'b0;
    wd_abort  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|m_req_i) begin
          state_d = ST_GRANT;
          gidx_d  = pick_idx;
          grant_d = N'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fwd_begin) begin
          state_d = ST_BUSY;
        end else if (!m_req_i[gidx_q]) begin
          rel = 1'b1;
        end else if (wd_hit) begin
          rel      = 1'b1;
          wd_abort = 1'b1;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (slave_done) begin
          rel = 1'b1;
        end else if (wd_hit) begin
          rel      = 1'b1;
          wd_abort = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rel) begin
      state_d = ST_IDLE;
      grant_d = '0;
      ptr_d   = next_ptr;
    end
    if (wd_abort) begin
      timeout_d = 1'b1;
      abort_d   = grant_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      abort_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      abort_q   <= abort_d;
    end
  end

  assign m_grant_o = grant_q;
  assign timeout_o = timeout_q;

  // Master fields reach the slaves only while a grant is held.
  always_comb begin
    bus_addrData_o         = '0;
    bus_byteEnables_o      = '0;
    bus_burstSize_o        = '0;
    bus_readNWrite_o       = 1'b0;
    bus_dataValid_o        = 1'b0;
    bus_beginTransaction_o = fwd_begin;
    if (active) begin
      bus_addrData_o    = addr_a[gidx_q];
      bus_byteEnables_o = be_a[gidx_q];
      bus_burstSize_o   = burst_a[gidx_q];
      bus_readNWrite_o  = m_readNWrite_i[gidx_q];
      bus_dataValid_o   = m_dataValid_i[gidx_q];
    end
  end

  // Slave responses go back to the owner only during the data phase.
  always_comb begin
    m_addrData_o       = '0;
    m_dataValid_o      = '0;
    m_endTransaction_o = '0;
    m_error_o          = abort_q;
    if (in_busy) begin
      m_addrData_o       = bus_addrData_i;
      m_dataValid_o      = bus_dataValid_i ? grant_q : '0;
      m_endTransaction_o = bus_endTransaction_i ? grant_q : '0;
      m_error_o          = abort_q | (bus_error_i ? grant_q : '0);
    end
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Bench for simple_bus_arbiter: scenario tasks plus randomized transactions
// checked against a round-robin model of the grant order and transaction timing.
module tb_simple_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_req, m_grant, m_rnw, m_begin, m_dv_in;
  logic [N-1:0]    m_dv_out, m_end_out, m_err_out;
  logic [32*N-1:0] m_addr;
  logic [4*N-1:0]  m_be;
  logic [8*N-1:0]  m_burst;
  logic [31:0]     m_rdata, bus_addr_o, bus_rdata;
  logic [3:0]      bus_be;
  logic [7:0]      bus_burst;
  logic            bus_rnw, bus_begin, bus_dv_o;
  logic            bus_end_i, bus_dv_i, bus_busy, bus_err, timeout;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  simple_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO), .CNT_W(11)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_grant_o(m_grant),
    .m_addrData_i(m_addr), .m_byteEnables_i(m_be), .m_burstSize_i(m_burst),
    .m_readNWrite_i(m_rnw), .m_beginTransaction_i(m_begin), .m_dataValid_i(m_dv_in),
    .m_addrData_o(m_rdata), .m_dataValid_o(m_dv_out), .m_endTransaction_o(m_end_out),
    .m_error_o(m_err_out),
    .bus_addrData_o(bus_addr_o), .bus_byteEnables_o(bus_be), .bus_burstSize_o(bus_burst),
    .bus_readNWrite_o(bus_rnw), .bus_beginTransaction_o(bus_begin), .bus_dataValid_o(bus_dv_o),
    .bus_addrData_i(bus_rdata), .bus_endTransaction_i(bus_end_i), .bus_dataValid_i(bus_dv_i),
    .bus_busy_i(bus_busy), .bus_error_i(bus_err),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Round-robin rule: first requester at or after the pointer, modulo N.
  function automatic int rr_model(input logic [N-1:0] mask, input int ptr);
    for (int off = 0; off < N; off++)
      if (mask[(ptr + off) % N]) return (ptr + off) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_rnw = '0; m_begin = '0; m_dv_in = '0;
    m_addr = '0; m_be = '0; m_burst = '0;
    bus_rdata = '0; bus_end_i = 1'b0; bus_dv_i = 1'b0; bus_busy = 1'b0; bus_err = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (m_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b exp 0000", m_grant); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", timeout); end
    rst_n = 1'b1;
    // Walk master 1 into the data phase, then pull reset mid-cycle.
    m_req = 4'b0010; m_begin = 4'b0010; m_rnw = 4'b0010;
    m_addr = {$urandom, $urandom, $urandom, $urandom};
    m_be = 16'hFFFF; m_burst = 32'h0505_0505;
    tick();
    tick();
    m_dv_in = 4'b1111; bus_dv_i = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (m_grant !== '0) begin errors++; $display("FAIL rst_busy_grant: got %b exp 0000", m_grant); end
    checks++; if (bus_addr_o !== '0) begin errors++; $display("FAIL rst_busy_addr: got %h exp 0", bus_addr_o); end
    checks++; if ({bus_be, bus_burst, bus_rnw, bus_begin, bus_dv_o} !== '0) begin
      errors++; $display("FAIL rst_busy_ctrl: got %h exp 0", {bus_be, bus_burst, bus_rnw, bus_begin, bus_dv_o}); end
    checks++; if ({m_dv_out, m_end_out, m_err_out} !== '0) begin
      errors++; $display("FAIL rst_busy_resp: got %h exp 0", {m_dv_out, m_end_out, m_err_out}); end
    checks++; if (m_rdata !== '0) begin errors++; $display("FAIL rst_busy_rdata: got %h exp 0", m_rdata); end
    clear_inputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_ptr = 0;
    m_req = 4'b0100;
    tick();
    checks++; if (m_grant !== 4'b0100) begin errors++; $display("FAIL rst_release_grant: got %b exp 0100", m_grant); end
  endtask

  task automatic test_single_read();
    logic [31:0] data;
    do_reset();
    m_req = 4'b0001; m_begin = 4'b0001; m_rnw = 4'b0001;
    m_addr[31:0] = 32'h8000_0010; m_be[3:0] = 4'hF; m_burst[7:0] = 8'd3;
    #1;
    checks++; if (m_grant !== 4'b0000) begin errors++; $display("FAIL single_pregrant: got %b exp 0000", m_grant); end
    tick();
    checks++; if (m_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b exp 0001", m_grant); end
    checks++; if (bus_begin !== 1'b1) begin errors++; $display("FAIL single_begin: got %b exp 1", bus_begin); end
    checks++; if (bus_addr_o !== 32'h8000_0010) begin errors++; $display("FAIL single_addr: got %h exp 80000010", bus_addr_o); end
    checks++; if (bus_burst !== 8'd3 || bus_rnw !== 1'b1) begin
      errors++; $display("FAIL single_burst_rnw: got %0d/%b exp 3/1", bus_burst, bus_rnw); end
    tick();
    m_req = '0; m_begin = '0;
    for (int k = 0; k < 4; k++) begin
      data = $urandom;
      bus_dv_i = 1'b1; bus_rdata = data; bus_end_i = (k == 3);
      #1;
      checks++; if (m_dv_out !== 4'b0001) begin errors++; $display("FAIL single_beat_dv%0d: got %b exp 0001", k, m_dv_out); end
      checks++; if (m_rdata !== data) begin errors++; $display("FAIL single_beat_data%0d: got %h exp %h", k, m_rdata, data); end
      checks++; if (m_end_out !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL single_beat_end%0d: got %b", k, m_end_out); end
      tick();
    end
    bus_dv_i = 1'b0; bus_end_i = 1'b0;
    checks++; if (m_grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b exp 0000", m_grant); end
  endtask

  task automatic test_round_robin();
    int g;
    int phase;
    logic [N-1:0] exp_g;
    do_reset();
    m_req = '1; m_begin = '1; m_dv_in = '1;
    m_addr = {$urandom, $urandom, $urandom, $urandom};
    g = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      phase = cyc % 4;
      if (phase == 0) g = rr_model(m_req, model_ptr);
      tick();
      bus_end_i = (phase == 2); bus_dv_i = (phase == 2);
      #1;
      exp_g = (phase < 3) ? (4'(1) << g) : 4'b0000;
      checks++; if (m_grant !== exp_g) begin errors++; $display("FAIL rr_grant cyc%0d: got %b exp %b", cyc, m_grant, exp_g); end
      checks++; if (bus_begin !== (phase == 0)) begin errors++; $display("FAIL rr_begin cyc%0d: got %b", cyc, bus_begin); end
      if (phase < 3) begin
        checks++; if (bus_addr_o !== m_addr[32*g +: 32]) begin
          errors++; $display("FAIL rr_addr cyc%0d: got %h exp %h", cyc, bus_addr_o, m_addr[32*g +: 32]); end
      end
      if (phase == 2) model_ptr = (g + 1) % N;
    end
    clear_inputs();
  endtask

  task automatic test_drop_req();
    int g;
    do_reset();
    m_req = 4'b0100;
    tick();
    checks++; if (m_grant !== 4'b0100) begin errors++; $display("FAIL drop_grant2: got %b exp 0100", m_grant); end
    model_ptr = 3;
    m_req = 4'b1001;
    tick();
    checks++; if (m_grant !== 4'b0000) begin errors++; $display("FAIL drop_release: got %b exp 0000", m_grant); end
    g = rr_model(m_req, model_ptr);
    tick();
    checks++; if (m_grant !== (4'(1) << g)) begin errors++; $display("FAIL drop_next_grant: got %b exp %b", m_grant, 4'(1) << g); end
    m_req = '0;
    tick();
  endtask

  task automatic test_busy_hold();
    do_reset();
    m_req = 4'b0010; m_begin = 4'b0010; bus_busy = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus_begin !== 1'b0) begin errors++; $display("FAIL busy_withheld%0d: got %b exp 0", k, bus_begin); end
      checks++; if (m_grant !== 4'b0010) begin errors++; $display("FAIL busy_grant%0d: got %b exp 0010", k, m_grant); end
      tick();
    end
    bus_busy = 1'b0;
    #1;
    checks++; if (bus_begin !== 1'b1) begin errors++; $display("FAIL busy_forward: got %b exp 1", bus_begin); end
    tick();
    #1;
    checks++; if (bus_begin !== 1'b0) begin errors++; $display("FAIL busy_ignored_begin: got %b exp 0", bus_begin); end
    bus_end_i = 1'b1; bus_dv_i = 1'b1;
    #1;
    checks++; if (m_end_out !== 4'b0010) begin errors++; $display("FAIL busy_end: got %b exp 0010", m_end_out); end
    tick();
    clear_inputs();
    checks++; if (m_grant !== 4'b0000) begin errors++; $display("FAIL busy_release: got %b exp 0000", m_grant); end
  endtask

  task automatic test_timeout();
    int g;
    do_reset();
    m_req = 4'b1000; m_begin = 4'b1000;
    tick();
    m_req = 4'b1011;
    for (int k = 0; k <= TO; k++) begin
      if (k == TO) begin
        bus_end_i = 1'b1; bus_dv_i = 1'b1;
      end
      #1;
      checks++; if (timeout !== (k == TO)) begin errors++; $display("FAIL to_pulse k%0d: got %b", k, timeout); end
      checks++; if (m_err_out !== ((k == TO) ? 4'b1000 : 4'b0000)) begin
        errors++; $display("FAIL to_err k%0d: got %b", k, m_err_out); end
      checks++; if (m_grant !== ((k < TO) ? 4'b1000 : 4'b0000)) begin
        errors++; $display("FAIL to_grant k%0d: got %b", k, m_grant); end
      if (k == TO) begin
        checks++; if ({m_end_out, m_dv_out} !== '0) begin
          errors++; $display("FAIL to_late_end: got %b exp 0", {m_end_out, m_dv_out}); end
      end
      if (k < TO) tick();
    end
    model_ptr = 0;
    g = rr_model(m_req, model_ptr);
    tick();
    bus_end_i = 1'b0; bus_dv_i = 1'b0;
    #1;
    checks++; if (m_grant !== (4'(1) << g)) begin errors++; $display("FAIL to_next_grant: got %b exp %b", m_grant, 4'(1) << g); end
    checks++; if (timeout !== 1'b0 || m_err_out !== '0) begin
      errors++; $display("FAIL to_pulse_width: got %b/%b exp 0/0", timeout, m_err_out); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int g, nb;
    logic use_err, last;
    logic [N-1:0] mask, exp_g;
    logic [31:0] data;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      mask = 4'($urandom_range(1, 15));
      m_req = mask; m_begin = '1;
      m_addr = {$urandom, $urandom, $urandom, $urandom};
      m_be = 16'($urandom); m_burst = $urandom; m_rnw = 4'($urandom); m_dv_in = 4'($urandom);
      g = rr_model(mask, model_ptr);
      exp_g = 4'(1) << g;
      tick();
      checks++; if (m_grant !== exp_g) begin errors++; $display("FAIL rnd_grant t%0d: got %b exp %b", t, m_grant, exp_g); end
      checks++; if ({bus_addr_o, bus_be, bus_burst, bus_rnw, bus_dv_o} !==
                    {m_addr[32*g +: 32], m_be[4*g +: 4], m_burst[8*g +: 8], m_rnw[g], m_dv_in[g]}) begin
        errors++; $display("FAIL rnd_mux t%0d: got %h exp %h", t, {bus_addr_o, bus_be, bus_burst, bus_rnw, bus_dv_o},
                           {m_addr[32*g +: 32], m_be[4*g +: 4], m_burst[8*g +: 8], m_rnw[g], m_dv_in[g]}); end
      checks++; if (bus_begin !== 1'b1) begin errors++; $display("FAIL rnd_begin t%0d: got %b exp 1", t, bus_begin); end
      tick();
      nb = $urandom_range(1, 4);
      use_err = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 2) == 0) begin
          bus_dv_i = 1'b0; bus_end_i = 1'b0; bus_err = 1'b0;
          #1;
          checks++; if ({m_dv_out, m_end_out, m_err_out} !== '0) begin
            errors++; $display("FAIL rnd_gap t%0d: got %h exp 0", t, {m_dv_out, m_end_out, m_err_out}); end
          tick();
        end
        last = (b == nb - 1);
        data = $urandom;
        bus_rdata = data;
        bus_err   = last && use_err;
        bus_dv_i  = !(last && use_err);
        bus_end_i = last && !use_err;
        #1;
        checks++; if (m_dv_out !== (bus_dv_i ? exp_g : 4'b0000)) begin
          errors++; $display("FAIL rnd_dv t%0d b%0d: got %b", t, b, m_dv_out); end
        checks++; if (m_end_out !== (bus_end_i ? exp_g : 4'b0000) || m_err_out !== (bus_err ? exp_g : 4'b0000)) begin
          errors++; $display("FAIL rnd_end_err t%0d b%0d: got %b/%b", t, b, m_end_out, m_err_out); end
        checks++; if (m_rdata !== data) begin errors++; $display("FAIL rnd_rdata t%0d b%0d: got %h exp %h", t, b, m_rdata, data); end
        tick();
      end
      bus_dv_i = 1'b0; bus_end_i = 1'b0; bus_err = 1'b0;
      #1;
      checks++; if (m_grant !== 4'b0000 || m_err_out !== 4'b0000) begin
        errors++; $display("FAIL rnd_release t%0d: got %b/%b exp 0000/0000", t, m_grant, m_err_out); end
      model_ptr = (g + 1) % N;
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_drop_req();
    test_busy_hold();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
